// File: rtl/nv_ram_rwsthp_param.sv
// Purpose: parametrised 1R1W synchronous RAM with registered read address, bypass mux and enabled output register.
// Latency: read 2 cycles (re at N, ore at N+1, dout after edge N+1); bypass 1 cycle (byp_sel+ore at N).
// Backpressure: none; ore=0 holds dout/dout_vld, re/we are ignored while init_busy=1.
//
// Ports: clk/rstn (async active-low), ra/re read address+enable, ore output-register enable,
//        dout/dout_vld registered data + validity, wa/we/di write port, byp_sel/dbyp bypass source,
//        pwrbus_ram_pd (accepted, no effect), init_busy (clearing sweep in progress).
// Optional feature: define NV_RAM_RWSTHP_INIT_CLEAR_EN to compile in the post-reset zeroing sweep.
module nv_ram_rwsthp_param #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 80,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic             byp_sel,
    input  logic [WIDTH-1:0] dbyp,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic             init_busy
);

    // One extra bit so DEPTH == 2^AW still compares correctly.
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra_d;
    logic             rd_pend;
    logic             busy;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             re_acc;
    logic             we_acc;
    logic [WIDTH-1:0] ram_q;

    // Power-bus control is a pass-through of the macro interface only.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

`ifdef NV_RAM_RWSTHP_INIT_CLEAR_EN
    typedef enum logic [1:0] {IDLE_RST, CLEAR, READY} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    // Reset lands directly in CLEAR so the sweep starts on the first edge after release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            IDLE_RST: begin
                busy      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = CLEAR;
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = READY;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign clr_addr = cnt;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign init_busy = busy;
    assign re_acc    = re & ~busy;
    assign we_acc    = we & ~busy & ({1'b0, wa} < DEPTH_C);

    // Storage has no reset; the sweep (when built in) owns the write port while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (we_acc) begin
            mem[wa] <= di;
        end
    end

    // Array read on the registered address: a same-edge write is seen next cycle,
    // while a write to ra_d in an ore cycle leaves dout with the old word.
    assign ram_q = ({1'b0, ra_d} < DEPTH_C) ? mem[ra_d] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ra_d     <= '0;
            rd_pend  <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            if (re_acc) begin
                ra_d <= ra;
            end
            // A new read issued in the same cycle as ore keeps the pending flag set.
            if (ore) begin
                rd_pend  <= re_acc;
                dout     <= byp_sel ? dbyp : ram_q;
                dout_vld <= byp_sel | rd_pend;
            end else if (re_acc) begin
                rd_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsthp_param.sv
module tb_nv_ram_rwsthp_param;

    localparam int WIDTH = 18;
    localparam int DEPTH = 80;
    localparam int AW    = 7;

    logic             clk;
    logic             rstn;
    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] di;
    logic             byp_sel;
    logic [WIDTH-1:0] dbyp;
    logic [31:0]      pwrbus_ram_pd;
    logic             init_busy;

    int checks = 0;
    int errors = 0;
    int n;

    // Scoreboard entries: {expected dout_vld, expected dout}
    logic [WIDTH:0] exp_q[$];

    nv_ram_rwsthp_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
        .dout(dout), .dout_vld(dout_vld), .wa(wa), .we(we), .di(di),
        .byp_sel(byp_sel), .dbyp(dbyp), .pwrbus_ram_pd(pwrbus_ram_pd),
        .init_busy(init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic vld, input logic [WIDTH-1:0] d);
        exp_q.push_back({vld, d});
    endtask

    task automatic pop_check(input string tag);
        logic [WIDTH:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_dout"}, 32'(dout), 32'(e[WIDTH-1:0]));
            check({tag, "_vld"}, 32'(dout_vld), 32'(e[WIDTH]));
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        we = 1'b1; wa = a; di = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        re = 1'b1; ra = a;
        tick();
        re = 1'b0; ore = 1'b1;
        push_exp(1'b1, d);
        tick();
        ore = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        rstn = 1'b0; ra = '0; re = 1'b0; ore = 1'b0; wa = '0; we = 1'b0;
        di = '0; byp_sel = 1'b0; dbyp = '0; pwrbus_ram_pd = 32'hA5A5_0F0F;
        #3;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_vld", 32'(dout_vld), 32'd0);
`ifdef NV_RAM_RWSTHP_INIT_CLEAR_EN
        check("rst_busy", 32'(init_busy), 32'd1);
`else
        check("rst_busy", 32'(init_busy), 32'd0);
`endif
        tick();
        tick();
        rstn = 1'b1;

`ifdef NV_RAM_RWSTHP_INIT_CLEAR_EN
        // Full sweep: busy for exactly DEPTH edges after release.
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (!init_busy) break;
        end
        check("sweep1_len", 32'(n), 32'(DEPTH));
`else
        tick();
        check("nomacro_busy", 32'(init_busy), 32'd0);
        wr(7'd37, 18'h0);
`endif
        rd("rd37_zero", 7'd37, 18'h0);

        wr(7'd5, 18'h2AAAA);
        rd("rd5", 7'd5, 18'h2AAAA);

        // Same-cycle write/read to 9, then write in the ore cycle must not reach dout.
        we = 1'b1; wa = 7'd9; di = 18'h11; re = 1'b1; ra = 7'd9;
        tick();
        re = 1'b0; ore = 1'b1; we = 1'b1; wa = 7'd9; di = 18'h22;
        push_exp(1'b1, 18'h11);
        tick();
        we = 1'b0; ore = 1'b0;
        pop_check("collide9");
        rd("rd9_new", 7'd9, 18'h22);

        // Bypass without a pending read, then hold with ore low.
        byp_sel = 1'b1; dbyp = 18'h3FFFF; ore = 1'b1;
        push_exp(1'b1, 18'h3FFFF);
        tick();
        byp_sel = 1'b0; dbyp = '0; ore = 1'b0;
        pop_check("byp");
        tick();
        tick();
        check("byp_hold_dout", 32'(dout), 32'h3FFFF);
        check("byp_hold_vld", 32'(dout_vld), 32'd1);

        // ore with no pending read: RAM word at ra_d (9) but not valid.
        ore = 1'b1;
        push_exp(1'b0, 18'h22);
        tick();
        ore = 1'b0;
        pop_check("ore_nopend");

        // Out-of-range write dropped; aliased address untouched; out-of-range read gives zero.
        wr(7'd20, 18'h1234);
        wr(7'd100, 18'h5);
        rd("rd20_alias", 7'd20, 18'h1234);
        rd("rd100_oor", 7'd100, 18'h0);

        // Back-to-back reads, one per cycle.
        for (int i = 0; i < 4; i++) wr(7'(40 + i), 18'(32'h100 + i * 7));
        for (int i = 0; i < 5; i++) begin
            re = (i < 4);
            ra = 7'(40 + i);
            ore = (i > 0);
            if (i > 0) push_exp(1'b1, 18'(32'h100 + (i - 1) * 7));
            tick();
            if (i > 0) pop_check("b2b");
        end
        re = 1'b0; ore = 1'b0;

        // Reset in the middle of operation.
        n = 0;
        rstn = 1'b0;
        #1;
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_vld", 32'(dout_vld), 32'd0);
        tick();
        rstn = 1'b1;

`ifdef NV_RAM_RWSTHP_INIT_CLEAR_EN
        // Interrupt the sweep at count 40 after making dout non-zero via bypass.
        for (int i = 0; i < 40; i++) begin
            ore = (i == 10); byp_sel = (i == 10); dbyp = 18'h0ABCD;
            tick();
        end
        ore = 1'b0; byp_sel = 1'b0;
        check("sweep40_busy", 32'(init_busy), 32'd1);
        check("sweep40_byp", 32'(dout), 32'h0ABCD);
        rstn = 1'b0;
        #1;
        check("sweeprst_dout", 32'(dout), 32'd0);
        check("sweeprst_vld", 32'(dout_vld), 32'd0);
        tick();
        rstn = 1'b1;
        // Restarted sweep: full length, bypass works, writes are ignored.
        n = 0;
        while (n < 200) begin
            if (n == 20) begin
                we = 1'b1; wa = 7'd3; di = 18'h77; re = 1'b1; ra = 7'd3;
                ore = 1'b1; byp_sel = 1'b1; dbyp = 18'h15A5A;
                push_exp(1'b1, 18'h15A5A);
            end
            tick();
            n++;
            if (n == 21) begin
                pop_check("clear_byp");
                we = 1'b0; re = 1'b0; ore = 1'b0; byp_sel = 1'b0;
            end
            if (!init_busy) break;
        end
        check("sweep2_len", 32'(n), 32'(DEPTH));
        rd("rd3_cleared", 7'd3, 18'h0);
        rd("rd5_cleared", 7'd5, 18'h0);
`else
        tick();
        check("nomacro_busy2", 32'(init_busy), 32'd0);
        wr(7'd3, 18'h77);
        rd("rd3_after_rst", 7'd3, 18'h77);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
